// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch target predictor: entry layout,
// counter encodings and PC index/tag extraction.
package bp_pkg;

    // Entry fields are sized for the widest supported configuration; the
    // predictor narrows them with casts to its own XLEN/TAG_BITS/CTR_BITS.
    localparam int unsigned BP_MAX_XLEN = 64;
    localparam int unsigned BP_MAX_TAG  = 32;
    localparam int unsigned BP_MAX_CTR  = 8;

    typedef struct packed {
        logic                   valid;
        logic                   is_jump;
        logic [BP_MAX_TAG-1:0]  tag;
        logic [BP_MAX_XLEN-1:0] target;
        logic [BP_MAX_CTR-1:0]  ctr;
    } bp_entry_t;

    function automatic logic [BP_MAX_CTR-1:0] bp_ctr_weak(input int unsigned ctr_bits);
        return BP_MAX_CTR'(1) << (ctr_bits - 1);
    endfunction

    function automatic logic [BP_MAX_CTR-1:0] bp_ctr_strong(input int unsigned ctr_bits);
        return (BP_MAX_CTR'(1) << ctr_bits) - BP_MAX_CTR'(1);
    endfunction

    function automatic logic [BP_MAX_XLEN-1:0] bp_index(input logic [BP_MAX_XLEN-1:0] pc,
                                                        input int unsigned idx_bits);
        return (pc >> 2) & ((BP_MAX_XLEN'(1) << idx_bits) - BP_MAX_XLEN'(1));
    endfunction

    function automatic logic [BP_MAX_XLEN-1:0] bp_tag(input logic [BP_MAX_XLEN-1:0] pc,
                                                      input int unsigned idx_bits,
                                                      input int unsigned tag_bits);
        return (pc >> (idx_bits + 2)) & ((BP_MAX_XLEN'(1) << tag_bits) - BP_MAX_XLEN'(1));
    endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a CTR_BITS-wide saturating direction counter.
module bp_sat_counter #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] ctr_in,
    input  logic                inc,
    input  logic                dec,
    input  logic                set_max,
    output logic [CTR_BITS-1:0] ctr_out
);

    always_comb begin
        ctr_out = ctr_in;
        if (set_max) begin
            ctr_out = '1;
        end else if (inc && (ctr_in != '1)) begin
            ctr_out = ctr_in + CTR_BITS'(1);
        end else if (dec && (ctr_in != '0)) begin
            ctr_out = ctr_in - CTR_BITS'(1);
        end
    end

endmodule

// File: rtl/branch_target_predictor.sv
// Flop-based BTB with per-entry saturating direction counters: same-cycle
// fetch prediction, ID-stage training, mispredict detection and perf counters.
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned TAG_BITS = 10,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned PERF_W   = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [XLEN-1:0]   lkp_pc,
    output logic              lkp_hit,
    output logic              lkp_taken,
    output logic [XLEN-1:0]   lkp_target,
    input  logic              upd_valid,
    input  logic [XLEN-1:0]   upd_pc,
    input  logic              upd_taken,
    input  logic [XLEN-1:0]   upd_target,
    input  logic              upd_is_jump,
    input  logic              upd_pred_taken,
    input  logic [XLEN-1:0]   upd_pred_target,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_pc,
    input  logic              invalidate,
    output logic [PERF_W-1:0] perf_branches,
    output logic [PERF_W-1:0] perf_mispredicts
);

    localparam int unsigned IDX = $clog2(ENTRIES);

    bp_entry_t mem_q [ENTRIES];
    bp_entry_t mem_d [ENTRIES];

    logic [PERF_W-1:0]   perf_branches_q, perf_branches_d;
    logic [PERF_W-1:0]   perf_mispredicts_q, perf_mispredicts_d;

    logic [IDX-1:0]      lkp_idx, upd_idx;
    logic [TAG_BITS-1:0] lkp_tag, upd_tag;
    bp_entry_t           lkp_e, upd_e, new_e;
    logic [CTR_BITS-1:0] lkp_ctr, upd_ctr, upd_ctr_next;
    logic                upd_hit;

    assign lkp_idx = IDX'(bp_index(BP_MAX_XLEN'(lkp_pc), IDX));
    assign lkp_tag = TAG_BITS'(bp_tag(BP_MAX_XLEN'(lkp_pc), IDX, TAG_BITS));
    assign upd_idx = IDX'(bp_index(BP_MAX_XLEN'(upd_pc), IDX));
    assign upd_tag = TAG_BITS'(bp_tag(BP_MAX_XLEN'(upd_pc), IDX, TAG_BITS));

    // Lookup reads the registered array only, so a same-cycle update is not bypassed.
    always_comb begin
        lkp_e      = mem_q[lkp_idx];
        lkp_ctr    = CTR_BITS'(lkp_e.ctr);
        lkp_hit    = lkp_e.valid && (TAG_BITS'(lkp_e.tag) == lkp_tag);
        lkp_taken  = lkp_hit && (lkp_ctr[CTR_BITS-1] || lkp_e.is_jump);
        lkp_target = lkp_hit ? XLEN'(lkp_e.target) : '0;
    end

    always_comb begin
        mispredict  = upd_valid && ((upd_taken != upd_pred_taken) ||
                                    (upd_taken && (upd_target != upd_pred_target)));
        redirect_pc = upd_taken ? upd_target : (upd_pc + XLEN'(4));
    end

    always_comb begin
        upd_e   = mem_q[upd_idx];
        upd_ctr = CTR_BITS'(upd_e.ctr);
        upd_hit = upd_e.valid && (TAG_BITS'(upd_e.tag) == upd_tag);
    end

    bp_sat_counter #(
        .CTR_BITS (CTR_BITS)
    ) u_upd_ctr (
        .ctr_in  (upd_ctr),
        .inc     (upd_taken),
        .dec     (!upd_taken),
        .set_max (upd_is_jump),
        .ctr_out (upd_ctr_next)
    );

    always_comb begin
        mem_d = mem_q;
        new_e = upd_e;
        if (upd_valid && !invalidate) begin
            if (upd_hit) begin
                new_e.ctr = BP_MAX_CTR'(upd_ctr_next);
                if (upd_is_jump) begin
                    new_e.is_jump = 1'b1;
                end
                if (upd_taken) begin
                    new_e.target = BP_MAX_XLEN'(upd_target);
                end
                mem_d[upd_idx] = new_e;
            end else if (upd_taken) begin
                new_e.valid   = 1'b1;
                new_e.is_jump = upd_is_jump;
                new_e.tag     = BP_MAX_TAG'(upd_tag);
                new_e.target  = BP_MAX_XLEN'(upd_target);
                new_e.ctr     = upd_is_jump ? bp_ctr_strong(CTR_BITS) : bp_ctr_weak(CTR_BITS);
                mem_d[upd_idx] = new_e;
            end
        end
        if (invalidate) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_d[i].valid = 1'b0;
            end
        end
    end

    // Perf counters still see updates that an invalidate suppresses.
    always_comb begin
        perf_branches_d    = perf_branches_q;
        perf_mispredicts_d = perf_mispredicts_q;
        if (upd_valid && (perf_branches_q != '1)) begin
            perf_branches_d = perf_branches_q + PERF_W'(1);
        end
        if (mispredict && (perf_mispredicts_q != '1)) begin
            perf_mispredicts_d = perf_mispredicts_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                mem_q[i].valid <= 1'b0;
            end
            perf_branches_q    <= '0;
            perf_mispredicts_q <= '0;
        end else begin
            mem_q              <= mem_d;
            perf_branches_q    <= perf_branches_d;
            perf_mispredicts_q <= perf_mispredicts_d;
        end
    end

    assign perf_branches    = perf_branches_q;
    assign perf_mispredicts = perf_mispredicts_q;

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor: a behavioural BTB model
// predicts each cycle's outputs, a negedge monitor compares them.
module tb_branch_target_predictor;

    localparam int unsigned XLEN     = 64;
    localparam int unsigned ENTRIES  = 16;
    localparam int unsigned TAG_BITS = 10;
    localparam int unsigned CTR_BITS = 2;
    localparam int unsigned PERF_W   = 6;
    localparam int unsigned IDX      = 4;
    localparam int          CTR_MAX  = (1 << CTR_BITS) - 1;
    localparam int unsigned PERF_MAX = (1 << PERF_W) - 1;

    logic              clk;
    logic              resetn;
    logic [XLEN-1:0]   lkp_pc;
    logic              lkp_hit;
    logic              lkp_taken;
    logic [XLEN-1:0]   lkp_target;
    logic              upd_valid;
    logic [XLEN-1:0]   upd_pc;
    logic              upd_taken;
    logic [XLEN-1:0]   upd_target;
    logic              upd_is_jump;
    logic              upd_pred_taken;
    logic [XLEN-1:0]   upd_pred_target;
    logic              mispredict;
    logic [XLEN-1:0]   redirect_pc;
    logic              invalidate;
    logic [PERF_W-1:0] perf_branches;
    logic [PERF_W-1:0] perf_mispredicts;

    branch_target_predictor #(
        .XLEN     (XLEN),
        .ENTRIES  (ENTRIES),
        .TAG_BITS (TAG_BITS),
        .CTR_BITS (CTR_BITS),
        .PERF_W   (PERF_W)
    ) u_dut (
        .clk              (clk),
        .resetn           (resetn),
        .lkp_pc           (lkp_pc),
        .lkp_hit          (lkp_hit),
        .lkp_taken        (lkp_taken),
        .lkp_target       (lkp_target),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_is_jump      (upd_is_jump),
        .upd_pred_taken   (upd_pred_taken),
        .upd_pred_target  (upd_pred_target),
        .mispredict       (mispredict),
        .redirect_pc      (redirect_pc),
        .invalidate       (invalidate),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          hit;
        bit          taken;
        logic [63:0] target;
        bit          mis;
        logic [63:0] redir;
        int unsigned pb;
        int unsigned pm;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;

    // Reference model: one record per BTB slot, plain integers for counters.
    bit          m_valid  [ENTRIES];
    int unsigned m_tag    [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_ctr    [ENTRIES];
    bit          m_jump   [ENTRIES];
    int unsigned m_pb, m_pm;

    function automatic int unsigned idx_of(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(ENTRIES));
    endfunction

    function automatic int unsigned tag_of(input logic [63:0] pc);
        return int'((pc / (64'd4 * 64'(ENTRIES))) % (64'd1 << TAG_BITS));
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("lkp_hit",          64'(lkp_hit),          64'(mon_e.hit));
            chk("lkp_taken",        64'(lkp_taken),        64'(mon_e.taken));
            chk("lkp_target",       lkp_target,            mon_e.target);
            chk("mispredict",       64'(mispredict),       64'(mon_e.mis));
            chk("redirect_pc",      redirect_pc,           mon_e.redir);
            chk("perf_branches",    64'(perf_branches),    64'(mon_e.pb));
            chk("perf_mispredicts", 64'(perf_mispredicts), 64'(mon_e.pm));
        end
    end

    task automatic step(input bit rn, input logic [63:0] lpc,
                        input bit uv, input logic [63:0] upc, input bit ut,
                        input logic [63:0] utgt, input bit uj, input bit upt,
                        input logic [63:0] uptgt, input bit inv);
        exp_t        e;
        int unsigned li, ui;
        bit          mis, uhit;
        @(posedge clk);
        #1;
        resetn          = rn;
        lkp_pc          = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_is_jump     = uj;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
        invalidate      = inv;

        li       = idx_of(lpc);
        e.hit    = m_valid[li] && (m_tag[li] == tag_of(lpc));
        e.taken  = e.hit && ((m_ctr[li] >= (CTR_MAX + 1) / 2) || m_jump[li]);
        e.target = e.hit ? m_target[li] : 64'd0;
        mis      = uv && ((ut != upt) || (ut && (utgt != uptgt)));
        e.mis    = mis;
        e.redir  = ut ? utgt : upc + 64'd4;
        e.pb     = m_pb;
        e.pm     = m_pm;
        sb.push_back(e);

        if (!rn) begin
            foreach (m_valid[i]) m_valid[i] = 1'b0;
            m_pb = 0;
            m_pm = 0;
        end else begin
            if (uv) begin
                if (m_pb < PERF_MAX) m_pb++;
                if (mis && (m_pm < PERF_MAX)) m_pm++;
            end
            if (inv) begin
                foreach (m_valid[i]) m_valid[i] = 1'b0;
            end else if (uv) begin
                ui   = idx_of(upc);
                uhit = m_valid[ui] && (m_tag[ui] == tag_of(upc));
                if (uhit) begin
                    if (uj) begin
                        m_ctr[ui]  = CTR_MAX;
                        m_jump[ui] = 1'b1;
                        if (ut) m_target[ui] = utgt;
                    end else if (ut) begin
                        m_ctr[ui]    = (m_ctr[ui] < CTR_MAX) ? m_ctr[ui] + 1 : CTR_MAX;
                        m_target[ui] = utgt;
                    end else begin
                        m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
                    end
                end else if (ut) begin
                    m_valid[ui]  = 1'b1;
                    m_tag[ui]    = tag_of(upc);
                    m_target[ui] = utgt;
                    m_ctr[ui]    = uj ? CTR_MAX : (CTR_MAX + 1) / 2;
                    m_jump[ui]   = uj;
                end
            end
        end
    endtask

    task automatic look(input logic [63:0] lpc);
        step(1'b1, lpc, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0, 64'd0, 1'b0);
    endtask

    function automatic logic [63:0] rand_pc();
        logic [63:0] pc;
        pc = (64'($urandom_range(0, 3)) << (IDX + 2)) |
             (64'($urandom_range(0, ENTRIES - 1)) << 2) |
             64'($urandom_range(0, 3));
        if ($urandom_range(0, 7) == 0) pc = pc | (64'd1 << 40);
        return pc;
    endfunction

    initial begin
        logic [63:0] lpc, upc, utgt, uptgt;
        bit          rn, uv, ut, uj, upt, inv;

        resetn          = 1'b0;
        lkp_pc          = '0;
        upd_valid       = 1'b0;
        upd_pc          = '0;
        upd_taken       = 1'b0;
        upd_target      = '0;
        upd_is_jump     = 1'b0;
        upd_pred_taken  = 1'b0;
        upd_pred_target = '0;
        invalidate      = 1'b0;
        foreach (m_valid[i]) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = '0;
            m_ctr[i]    = 0;
            m_jump[i]   = 1'b0;
        end
        m_pb = 0;
        m_pm = 0;
        repeat (2) @(posedge clk);

        // Directed walk through the bring-up scenarios.
        look(64'h100);
        step(1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 1'b0, 64'h0, 1'b0);
        look(64'h100);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 64'h100, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1'b1, 64'h80, 1'b0);
            look(64'h100);
        end
        step(1'b1, 64'h100, 1'b1, 64'h100, 1'b1, 64'h80, 1'b0, 1'b1, 64'h80, 1'b0);
        look(64'h140);
        step(1'b1, 64'h140, 1'b1, 64'h140, 1'b1, 64'h300, 1'b0, 1'b0, 64'h0, 1'b0);
        look(64'h140);
        look(64'h100);
        step(1'b1, 64'h200, 1'b1, 64'h200, 1'b1, 64'h400, 1'b1, 1'b0, 64'h0, 1'b0);
        look(64'h200);
        step(1'b1, 64'h300, 1'b1, 64'h300, 1'b1, 64'h500, 1'b0, 1'b0, 64'h0, 1'b1);
        look(64'h300);
        look(64'h200);
        step(1'b1, 64'h104, 1'b1, 64'h104, 1'b1, 64'h900, 1'b0, 1'b1, 64'h900, 1'b0);
        step(1'b0, 64'h104, 1'b1, 64'h108, 1'b1, 64'h900, 1'b0, 1'b0, 64'h0, 1'b0);
        look(64'h104);
        look(64'h108);

        for (int n = 0; n < 3000; n++) begin
            rn    = ($urandom_range(0, 599) != 0);
            upc   = rand_pc();
            lpc   = ($urandom_range(0, 2) == 0) ? upc : rand_pc();
            uv    = 1'($urandom_range(0, 1));
            uj    = ($urandom_range(0, 7) == 0);
            ut    = uj ? 1'b1 : 1'($urandom_range(0, 1));
            utgt  = {$urandom, $urandom};
            upt   = 1'($urandom_range(0, 1));
            uptgt = ($urandom_range(0, 1) == 0) ? utgt : {$urandom, $urandom};
            inv   = ($urandom_range(0, 49) == 0);
            step(rn, lpc, uv, upc, ut, utgt, uj, upt, uptgt, inv);
        end

        for (int k = 0; (k < 10) && (sb.size() != 0); k++) @(negedge clk);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
